// File: rtl/console_uart_tx.sv
// Console write strobes queued in a small FIFO and serialised as 8N1 UART
// frames, LSB first, with no idle gap between queued frames.
module console_uart_tx #(
   parameter int XLEN         = 32,
   parameter int CLKS_PER_BIT = 434,
   parameter int FIFO_DEPTH   = 16
) (
   input  logic                          clk,
   input  logic                          reset,
   input  logic [XLEN-1:0]               console_wdata,
   input  logic                          console_we,
   output logic                          txd,
   output logic                          busy,
   output logic                          overflow,
   output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

   localparam int AW   = $clog2(FIFO_DEPTH);
   localparam int CNTW = AW + 1;
   localparam int CW   = $clog2(CLKS_PER_BIT);
   localparam logic [CW-1:0]   LAST = CW'(CLKS_PER_BIT - 1);
   localparam logic [CNTW-1:0] FULL = CNTW'(FIFO_DEPTH);

   typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

   state_t          r_state;
   state_t          w_state_nxt;
   logic [CW-1:0]   r_cnt;
   logic [CW-1:0]   w_cnt_nxt;
   logic [2:0]      r_idx;
   logic [2:0]      w_idx_nxt;
   logic [7:0]      r_shift;
   logic [7:0]      w_shift_nxt;
   logic            r_txd;
   logic            w_txd_nxt;
   logic [7:0]      r_mem [FIFO_DEPTH];
   logic [AW-1:0]   r_wptr;
   logic [AW-1:0]   r_rptr;
   logic [CNTW-1:0] r_count;
   logic [CNTW-1:0] w_count_nxt;
   logic            r_busy;
   logic            r_ovf;
   logic            w_last;
   logic            w_pop;
   logic            w_push;
   logic            w_drop;
   logic            w_has_data;
   logic            w_unused;

   assign w_unused   = ^console_wdata[XLEN-1:8];
   assign w_last     = (r_cnt == LAST);
   assign w_has_data = (r_count != '0);

   // A push into a full FIFO is still accepted when a pop frees a slot.
   assign w_push = console_we && ((r_count != FULL) || w_pop);
   assign w_drop = console_we && !w_push;

   always_comb begin
      w_count_nxt = r_count;
      if (w_push && !w_pop) begin
         w_count_nxt = r_count + 1'b1;
      end else if (w_pop && !w_push) begin
         w_count_nxt = r_count - 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state <= IDLE;
         r_cnt   <= '0;
         r_idx   <= '0;
         r_shift <= '0;
         r_txd   <= 1'b1;
         r_wptr  <= '0;
         r_rptr  <= '0;
         r_count <= '0;
         r_busy  <= 1'b0;
         r_ovf   <= 1'b0;
      end else begin
         r_state <= w_state_nxt;
         r_cnt   <= w_cnt_nxt;
         r_idx   <= w_idx_nxt;
         r_shift <= w_shift_nxt;
         r_txd   <= w_txd_nxt;
         r_count <= w_count_nxt;
         r_busy  <= (w_state_nxt != IDLE) || (w_count_nxt != '0);
         if (w_push) begin
            r_wptr <= r_wptr + 1'b1;
         end
         if (w_pop) begin
            r_rptr <= r_rptr + 1'b1;
         end
         if (w_drop) begin
            r_ovf <= 1'b1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (w_push) begin
         r_mem[r_wptr] <= console_wdata[7:0];
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      unique case (r_state)
         IDLE: begin
            if (w_has_data) begin
               w_state_nxt = START;
            end
         end
         START: begin
            if (w_last) begin
               w_state_nxt = DATA;
            end
         end
         DATA: begin
            if (w_last && (r_idx == 3'd7)) begin
               w_state_nxt = STOP;
            end
         end
         STOP: begin
            if (w_last) begin
               w_state_nxt = w_has_data ? START : IDLE;
            end
         end
         default: w_state_nxt = IDLE;
      endcase
   end

   always_comb begin
      w_pop       = 1'b0;
      w_txd_nxt   = r_txd;
      w_shift_nxt = r_shift;
      w_idx_nxt   = r_idx;
      w_cnt_nxt   = w_last ? '0 : r_cnt + 1'b1;
      unique case (r_state)
         IDLE: begin
            w_cnt_nxt = '0;
            w_txd_nxt = 1'b1;
            if (w_has_data) begin
               w_pop       = 1'b1;
               w_shift_nxt = r_mem[r_rptr];
               w_txd_nxt   = 1'b0;
            end
         end
         START: begin
            if (w_last) begin
               w_txd_nxt = r_shift[0];
               w_idx_nxt = '0;
            end
         end
         DATA: begin
            if (w_last) begin
               if (r_idx == 3'd7) begin
                  w_txd_nxt = 1'b1;
               end else begin
                  w_shift_nxt = {1'b0, r_shift[7:1]};
                  w_txd_nxt   = r_shift[1];
                  w_idx_nxt   = r_idx + 1'b1;
               end
            end
         end
         STOP: begin
            // Chain straight into the next start bit when more is queued.
            if (w_last && w_has_data) begin
               w_pop       = 1'b1;
               w_shift_nxt = r_mem[r_rptr];
               w_txd_nxt   = 1'b0;
            end
         end
         default: w_txd_nxt = 1'b1;
      endcase
   end

   assign txd        = r_txd;
   assign busy       = r_busy;
   assign overflow   = r_ovf;
   assign fifo_count = r_count;

endmodule

// File: tb/tb_console_uart_tx.sv
// Bench for console_uart_tx: a line monitor decodes frames into a queue
// that each scenario compares against the bytes it expects.
module tb_console_uart_tx;

   localparam int CPB   = 4;
   localparam int DEPTH = 4;
   localparam int XLEN  = 32;

   logic            clk = 1'b0;
   logic            reset = 1'b1;
   logic            console_we = 1'b0;
   logic [XLEN-1:0] console_wdata = '0;
   logic            txd;
   logic            busy;
   logic            overflow;
   logic [2:0]      fifo_count;

   int         n_checks = 0;
   int         n_pass = 0;
   logic [7:0] exp_q[$];
   logic [8:0] rx_q[$];
   int         rd = 0;

   logic       m_act = 1'b0;
   int         m_idx = 0;
   logic [7:0] m_sh = '0;
   logic       m_ok = 1'b0;

   console_uart_tx #(
      .XLEN(XLEN),
      .CLKS_PER_BIT(CPB),
      .FIFO_DEPTH(DEPTH)
   ) dut (
      .clk(clk),
      .reset(reset),
      .console_wdata(console_wdata),
      .console_we(console_we),
      .txd(txd),
      .busy(busy),
      .overflow(overflow),
      .fifo_count(fifo_count)
   );

   always #5 clk = ~clk;

   // Frame decoder: start bit, 8 steady data bits, stop bit, CPB samples each.
   always @(negedge clk) begin
      if (reset) begin
         m_act <= 1'b0;
      end else if (!m_act) begin
         if (txd === 1'b0) begin
            m_act <= 1'b1;
            m_idx <= 1;
            m_ok  <= 1'b1;
         end
      end else begin
         m_idx <= m_idx + 1;
         if (m_idx < CPB) begin
            if (txd !== 1'b0) m_ok <= 1'b0;
         end else if (m_idx < 9 * CPB) begin
            if (m_idx % CPB == 0) m_sh[3'(m_idx / CPB - 1)] <= txd;
            else if (txd !== m_sh[3'(m_idx / CPB - 1)]) m_ok <= 1'b0;
         end else begin
            if (txd !== 1'b1) m_ok <= 1'b0;
            if (m_idx == 10 * CPB - 1) begin
               rx_q.push_back({m_ok && (txd === 1'b1), m_sh});
               m_act <= 1'b0;
            end
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      tick();
      reset = 1'b1;
      console_we = 1'b0;
      tick();
      reset = 1'b0;
   endtask

   task automatic test_reset();
      reset = 1'b1;
      console_we = 1'b0;
      tick();
      @(negedge clk);
      n_checks++;
      if (txd !== 1'b1) $display("FAIL reset_txd got=%b want=1", txd);
      else n_pass++;
      n_checks++;
      if (busy !== 1'b0) $display("FAIL reset_busy got=%b want=0", busy);
      else n_pass++;
      n_checks++;
      if (overflow !== 1'b0) $display("FAIL reset_ovf got=%b want=0", overflow);
      else n_pass++;
      n_checks++;
      if (fifo_count !== 3'd0) $display("FAIL reset_count got=%0d want=0", fifo_count);
      else n_pass++;
      tick();
      reset = 1'b0;
   endtask

   task automatic test_single();
      logic [47:0] tv;
      logic [47:0] ev;
      logic [47:0] bv;
      logic [2:0]  fc1;
      logic [2:0]  fc2;
      logic [7:0]  b;
      logic [8:0]  want;
      b = 8'h41;
      fc1 = '0;
      fc2 = '0;
      for (int c = 0; c < 48; c++) begin
         tick();
         console_we = (c == 0);
         console_wdata = 32'h0000_0041;
         if (c == 0) exp_q.push_back(b);
         @(negedge clk);
         tv[c] = txd;
         bv[c] = busy;
         if (c == 1) fc1 = fifo_count;
         if (c == 2) fc2 = fifo_count;
      end
      console_we = 1'b0;
      for (int c = 0; c < 48; c++) begin
         if (c >= 2 && c < 6) ev[c] = 1'b0;
         else if (c >= 6 && c < 38) ev[c] = b[3'((c - 6) / CPB)];
         else ev[c] = 1'b1;
      end
      n_checks++;
      if (tv !== ev) $display("FAIL single_line got=%h want=%h", tv, ev);
      else n_pass++;
      n_checks++;
      if (bv[1] !== 1'b1) $display("FAIL single_busy1 got=%b want=1", bv[1]);
      else n_pass++;
      n_checks++;
      if (bv[41] !== 1'b1) $display("FAIL single_busy41 got=%b want=1", bv[41]);
      else n_pass++;
      n_checks++;
      if (bv[42] !== 1'b0) $display("FAIL single_busy42 got=%b want=0", bv[42]);
      else n_pass++;
      n_checks++;
      if (fc1 !== 3'd1) $display("FAIL single_count1 got=%0d want=1", fc1);
      else n_pass++;
      n_checks++;
      if (fc2 !== 3'd0) $display("FAIL single_count2 got=%0d want=0", fc2);
      else n_pass++;
      while (rd < rx_q.size()) begin
         n_checks++;
         if (exp_q.size() == 0) begin
            $display("FAIL single_frame got=%h want=none", rx_q[rd]);
         end else begin
            want = {1'b1, exp_q.pop_front()};
            if (rx_q[rd] !== want) $display("FAIL single_frame got=%h want=%h", rx_q[rd], want);
            else n_pass++;
         end
         rd++;
      end
      n_checks++;
      if (exp_q.size() != 0) $display("FAIL single_missing got=%0d want=0", exp_q.size());
      else n_pass++;
   endtask

   task automatic test_upper_bits();
      int         w;
      logic [8:0] want;
      tick();
      console_we = 1'b1;
      console_wdata = 32'hDEAD_BE55;
      exp_q.push_back(8'h55);
      tick();
      console_we = 1'b0;
      w = 0;
      @(negedge clk);
      while (busy !== 1'b0 && w < 1000) begin
         @(negedge clk);
         w++;
      end
      n_checks++;
      if (busy !== 1'b0) $display("FAIL upper_idle got=%b want=0", busy);
      else n_pass++;
      while (rd < rx_q.size()) begin
         n_checks++;
         if (exp_q.size() == 0) begin
            $display("FAIL upper_frame got=%h want=none", rx_q[rd]);
         end else begin
            want = {1'b1, exp_q.pop_front()};
            if (rx_q[rd] !== want) $display("FAIL upper_frame got=%h want=%h", rx_q[rd], want);
            else n_pass++;
         end
         rd++;
      end
      n_checks++;
      if (exp_q.size() != 0) $display("FAIL upper_missing got=%0d want=0", exp_q.size());
      else n_pass++;
   endtask

   task automatic test_back_to_back();
      logic [7:0] bytes [3];
      int         ones;
      int         want_ones;
      int         first_low;
      logic       ov_any;
      logic [8:0] want;
      bytes[0] = 8'h48;
      bytes[1] = 8'h69;
      bytes[2] = 8'h0A;
      ones = 0;
      first_low = -1;
      ov_any = 1'b0;
      want_ones = 0;
      for (int i = 0; i < 3; i++) want_ones += ($countones(bytes[i]) + 1) * CPB;
      for (int c = 0; c < 130; c++) begin
         tick();
         console_we = (c < 3);
         if (c < 3) begin
            console_wdata = {24'hC0FFEE, bytes[c]};
            exp_q.push_back(bytes[c]);
         end
         @(negedge clk);
         if (c >= 2 && c <= 121 && txd === 1'b1) ones++;
         if (first_low < 0 && c > 0 && busy === 1'b0) first_low = c;
         ov_any = ov_any | overflow;
      end
      console_we = 1'b0;
      n_checks++;
      if (first_low !== 122) $display("FAIL b2b_busy_end got=%0d want=122", first_low);
      else n_pass++;
      n_checks++;
      if (ones !== want_ones) $display("FAIL b2b_high_cycles got=%0d want=%0d", ones, want_ones);
      else n_pass++;
      n_checks++;
      if (ov_any !== 1'b0) $display("FAIL b2b_ovf got=%b want=0", ov_any);
      else n_pass++;
      while (rd < rx_q.size()) begin
         n_checks++;
         if (exp_q.size() == 0) begin
            $display("FAIL b2b_frame got=%h want=none", rx_q[rd]);
         end else begin
            want = {1'b1, exp_q.pop_front()};
            if (rx_q[rd] !== want) $display("FAIL b2b_frame got=%h want=%h", rx_q[rd], want);
            else n_pass++;
         end
         rd++;
      end
      n_checks++;
      if (exp_q.size() != 0) $display("FAIL b2b_missing got=%0d want=0", exp_q.size());
      else n_pass++;
   endtask

   task automatic test_overflow();
      logic       ov5;
      logic       ov6;
      int         w;
      logic [8:0] want;
      do_reset();
      ov5 = 1'b0;
      ov6 = 1'b0;
      for (int c = 0; c < 8; c++) begin
         tick();
         console_we = (c < 6);
         console_wdata = 32'h30 + c;
         if (c < 5) exp_q.push_back(8'(8'h30 + c));
         @(negedge clk);
         if (c == 5) ov5 = overflow;
         if (c == 6) ov6 = overflow;
      end
      console_we = 1'b0;
      n_checks++;
      if (ov5 !== 1'b0) $display("FAIL ovf_c5 got=%b want=0", ov5);
      else n_pass++;
      n_checks++;
      if (ov6 !== 1'b1) $display("FAIL ovf_c6 got=%b want=1", ov6);
      else n_pass++;
      w = 0;
      while (busy !== 1'b0 && w < 1000) begin
         @(negedge clk);
         w++;
      end
      n_checks++;
      if (busy !== 1'b0) $display("FAIL ovf_idle got=%b want=0", busy);
      else n_pass++;
      n_checks++;
      if (overflow !== 1'b1) $display("FAIL ovf_sticky got=%b want=1", overflow);
      else n_pass++;
      while (rd < rx_q.size()) begin
         n_checks++;
         if (exp_q.size() == 0) begin
            $display("FAIL ovf_frame got=%h want=none", rx_q[rd]);
         end else begin
            want = {1'b1, exp_q.pop_front()};
            if (rx_q[rd] !== want) $display("FAIL ovf_frame got=%h want=%h", rx_q[rd], want);
            else n_pass++;
         end
         rd++;
      end
      n_checks++;
      if (exp_q.size() != 0) $display("FAIL ovf_missing got=%0d want=0", exp_q.size());
      else n_pass++;
   endtask

   task automatic test_full_pop_push();
      logic [2:0] fc5;
      logic [2:0] fc41;
      logic [2:0] fc42;
      logic       ov42;
      int         w;
      logic [8:0] want;
      do_reset();
      fc5 = '0;
      fc41 = '0;
      fc42 = '0;
      ov42 = 1'b1;
      for (int c = 0; c < 48; c++) begin
         tick();
         console_we = (c < 5 || c == 41);
         console_wdata = 32'hA0 + ((c < 5) ? c : 5);
         if (c < 5 || c == 41) exp_q.push_back(8'(8'hA0 + ((c < 5) ? c : 5)));
         @(negedge clk);
         if (c == 5) fc5 = fifo_count;
         if (c == 41) fc41 = fifo_count;
         if (c == 42) begin
            fc42 = fifo_count;
            ov42 = overflow;
         end
      end
      console_we = 1'b0;
      n_checks++;
      if (fc5 !== 3'd4) $display("FAIL full_count5 got=%0d want=4", fc5);
      else n_pass++;
      n_checks++;
      if (fc41 !== 3'd4) $display("FAIL full_count41 got=%0d want=4", fc41);
      else n_pass++;
      n_checks++;
      if (fc42 !== 3'd4) $display("FAIL full_count42 got=%0d want=4", fc42);
      else n_pass++;
      n_checks++;
      if (ov42 !== 1'b0) $display("FAIL full_ovf42 got=%b want=0", ov42);
      else n_pass++;
      w = 0;
      while (busy !== 1'b0 && w < 1000) begin
         @(negedge clk);
         w++;
      end
      n_checks++;
      if (busy !== 1'b0) $display("FAIL full_idle got=%b want=0", busy);
      else n_pass++;
      n_checks++;
      if (overflow !== 1'b0) $display("FAIL full_ovf_end got=%b want=0", overflow);
      else n_pass++;
      while (rd < rx_q.size()) begin
         n_checks++;
         if (exp_q.size() == 0) begin
            $display("FAIL full_frame got=%h want=none", rx_q[rd]);
         end else begin
            want = {1'b1, exp_q.pop_front()};
            if (rx_q[rd] !== want) $display("FAIL full_frame got=%h want=%h", rx_q[rd], want);
            else n_pass++;
         end
         rd++;
      end
      n_checks++;
      if (exp_q.size() != 0) $display("FAIL full_missing got=%0d want=0", exp_q.size());
      else n_pass++;
   endtask

   task automatic test_reset_mid();
      logic       t11;
      logic       b11;
      logic       o11;
      logic [2:0] f11;
      int         lows;
      int         w;
      logic [8:0] want;
      do_reset();
      t11 = 1'b0;
      b11 = 1'b1;
      o11 = 1'b1;
      f11 = '1;
      lows = 0;
      for (int c = 0; c < 71; c++) begin
         tick();
         reset = (c == 10);
         console_we = (c < 3);
         console_wdata = 32'h11 * (c + 1);
         @(negedge clk);
         if (c == 11) begin
            t11 = txd;
            b11 = busy;
            o11 = overflow;
            f11 = fifo_count;
         end
         if (c >= 11 && txd !== 1'b1) lows++;
      end
      console_we = 1'b0;
      n_checks++;
      if (t11 !== 1'b1) $display("FAIL mid_txd got=%b want=1", t11);
      else n_pass++;
      n_checks++;
      if (b11 !== 1'b0) $display("FAIL mid_busy got=%b want=0", b11);
      else n_pass++;
      n_checks++;
      if (f11 !== 3'd0) $display("FAIL mid_count got=%0d want=0", f11);
      else n_pass++;
      n_checks++;
      if (o11 !== 1'b0) $display("FAIL mid_ovf got=%b want=0", o11);
      else n_pass++;
      n_checks++;
      if (lows !== 0) $display("FAIL mid_quiet got=%0d want=0", lows);
      else n_pass++;
      tick();
      console_we = 1'b1;
      console_wdata = 32'h0000_005A;
      exp_q.push_back(8'h5A);
      tick();
      console_we = 1'b0;
      w = 0;
      @(negedge clk);
      while (busy !== 1'b0 && w < 1000) begin
         @(negedge clk);
         w++;
      end
      n_checks++;
      if (busy !== 1'b0) $display("FAIL mid_idle got=%b want=0", busy);
      else n_pass++;
      while (rd < rx_q.size()) begin
         n_checks++;
         if (exp_q.size() == 0) begin
            $display("FAIL mid_frame got=%h want=none", rx_q[rd]);
         end else begin
            want = {1'b1, exp_q.pop_front()};
            if (rx_q[rd] !== want) $display("FAIL mid_frame got=%h want=%h", rx_q[rd], want);
            else n_pass++;
         end
         rd++;
      end
      n_checks++;
      if (exp_q.size() != 0) $display("FAIL mid_missing got=%0d want=0", exp_q.size());
      else n_pass++;
   endtask

   initial begin
      test_reset();
      test_single();
      test_upper_bits();
      test_back_to_back();
      test_overflow();
      test_full_pop_push();
      // Frames queued before the abort must be discarded by the bench too.
      exp_q.delete();
      test_reset_mid();
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

// File: doc/console_uart_tx.md
Name: console_uart_tx

Overview:
- Serialises console writes from the processor top onto a UART TX line. Sits directly downstream of the top-level console_we/console_wdata outputs.
- Each console write strobe carries one character in the low byte of console_wdata. Characters are queued in a small FIFO and sent as 8N1 frames, LSB first.
- The processor never stalls for the console. On FIFO overflow the character is dropped and a sticky flag is raised.

Parameters:
- XLEN, 32: width of console_wdata. Must match the codebase XLEN.
- CLKS_PER_BIT, 434: clk cycles per UART bit (50 MHz / 115200). Must be ≥ 2.
- FIFO_DEPTH, 16: FIFO entries. Must be a power of 2 and ≥ 2.

Ports:
- clk, input, 1: single clock; all logic on its rising edge.
- reset, input, 1: synchronous, active-high reset.
- console_wdata, input, XLEN: character to send. Bits [7:0] are used; bits [XLEN-1:8] are ignored.
- console_we, input, 1: write strobe, one character per high cycle. May be high on consecutive cycles.
- txd, output, 1: UART serial out; idles high.
- busy, output, 1: high when state != IDLE or FIFO is non-empty.
- overflow, output, 1: sticky; set when a write is dropped.
- fifo_count, output, $clog2(FIFO_DEPTH)+1: current FIFO occupancy.

Behaviour:
- Reset, checked in the same clock edge it is sampled: txd=1, busy=0, overflow=0, fifo_count=0, state=IDLE, pointers and counters cleared. A reset mid-frame aborts the frame immediately (txd=1 next cycle) and discards all queued bytes.
- FIFO:
  - Push when console_we=1 and (count<FIFO_DEPTH, or a pop happens in the same cycle).
  - A push when full with no pop is dropped; overflow is set from the next cycle and held until reset.
  - Simultaneous push and pop leaves count unchanged.
  - Pointers wrap modulo FIFO_DEPTH.
- FSM states: IDLE, START, DATA, STOP. One bit-cycle counter (0..CLKS_PER_BIT-1) and one 3-bit index.
  - IDLE: txd=1. If count>0 at the edge: pop into an 8-bit shift register, txd<=0, go to START. A byte written in cycle N therefore drives txd low from cycle N+2 when the FSM was idle with an empty FIFO.
  - START: hold txd=0 for CLKS_PER_BIT cycles, then txd<=shift[0], index=0, go to DATA.
  - DATA: each bit lasts CLKS_PER_BIT cycles, then shift right. After bit 7 completes: txd<=1, go to STOP.
  - STOP: hold txd=1 for CLKS_PER_BIT cycles. At the final cycle, if count>0: pop, txd<=0, go directly to START (no idle gap between frames). Otherwise go to IDLE.
- Frame timing: exactly 10*CLKS_PER_BIT cycles from start-bit edge to end of stop bit. txd is registered and glitch-free.
- fifo_count and busy are registered and consistent with the FIFO state after each edge.
- Pop and push in the same cycle on an empty FIFO: the pop is not taken (count was 0). The byte is pushed and popped the next cycle.

Test Plan (CLKS_PER_BIT=4, FIFO_DEPTH=4 unless noted):
- Single write 0x00000041 in cycle 0 → txd=0 for cycles 2–5, then data bits 1,0,0,0,0,0,1,0 (4 cycles each), then stop=1 for cycles 38–41. busy falls after cycle 41; fifo_count returns to 0.
- Write 0xDEADBE55 → transmitted frame carries 0x55 (data bits 1,0,1,0,1,0,1,0); upper bits have no effect.
- Writes 0x48, 0x69, 0x0A on cycles 0,1,2 → three contiguous frames in order, 120 cycles total, no idle-high gap between stop and next start. overflow stays 0.
- Six consecutive writes 0x30..0x35 from idle → 0x30..0x34 transmitted. 0x35 is dropped (FIFO full at cycle 5). overflow=1 from cycle 6 and remains 1 after all frames finish.
- FIFO full (count=4) and a write in the final STOP cycle → pop and push are both accepted, count stays 4, overflow stays 0.
- Reset asserted for one cycle during the DATA state with 2 bytes queued → next cycle: txd=1, busy=0, fifo_count=0, overflow=0. No further frames; a new write afterwards transmits normally.
